// File: rtl/sp_tile_loader_if.sv
// Stream-in / pad write-port bundle for sp_tile_loader.
// SP_LOADER_LAST_CHECK_EN adds the s_last framing input and the sticky err output.
interface sp_tile_loader_if #(
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              wen;
    logic [8:0]        data_in_addr;
    logic [DATA_W-1:0] data_in;
    logic              tile_valid;
    logic              tile_bank;
    logic              tile_release;
`ifdef SP_LOADER_LAST_CHECK_EN
    logic              s_last;
    logic              err;

    modport master (
        output s_valid, s_data, s_last, tile_release,
        input  s_ready, wen, data_in_addr, data_in, tile_valid, tile_bank, err
    );
    modport slave (
        input  s_valid, s_data, s_last, tile_release,
        output s_ready, wen, data_in_addr, data_in, tile_valid, tile_bank, err
    );
`else
    modport master (
        output s_valid, s_data, tile_release,
        input  s_ready, wen, data_in_addr, data_in, tile_valid, tile_bank
    );
    modport slave (
        input  s_valid, s_data, tile_release,
        output s_ready, wen, data_in_addr, data_in, tile_valid, tile_bank
    );
`endif
endinterface

// File: rtl/sp_tile_loader.sv
// Ping-pong tile loader feeding the systolic scratch pad write port from a valid/ready stream.
// Optional feature macro: SP_LOADER_LAST_CHECK_EN (s_last framing check with sticky err).
module sp_tile_loader #(
    parameter int SYS_WIDTH  = 64,
    parameter int SYS_HEIGHT = 1,
    parameter int DATA_W     = 32
) (
    input logic            write_clk,
    input logic            rst_n,
    sp_tile_loader_if.slave bus
);
    localparam int         NBRAM    = SYS_HEIGHT + SYS_WIDTH;
    localparam int         WORDS    = 2 * NBRAM;
    localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

    typedef enum logic [1:0] {WR_RESET, WR_FILL, WR_STALL} wr_state_t;
    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_t;

    wr_state_t         r_wrState;
    bank_state_t       r_bankState [2];
    bank_state_t       w_bankNext  [2];
    logic              r_wrBank;
    logic              r_rdBank;
    logic [7:0]        r_idx;
    logic              r_sReady;
    logic              r_wen;
    logic [8:0]        r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_tileValid;

    logic              w_hs;
    logic              w_idxEnd;
    logic              w_close;
    logic              w_rel;
    logic              w_wrBankNext;
    logic              w_rdBankNext;
    logic [1:0]        w_full;
    logic [1:0]        w_fullNext;

    assign w_hs     = bus.s_valid & r_sReady;
    assign w_idxEnd = (r_idx == LAST_IDX);

`ifdef SP_LOADER_LAST_CHECK_EN
    logic r_err;
    assign w_close = w_hs & (w_idxEnd | bus.s_last);
    assign bus.err = r_err;
`else
    assign w_close = w_hs & w_idxEnd;
`endif

    // A stale tile_valid right after a release must not free the next bank twice.
    assign w_rel        = bus.tile_release & r_tileValid & w_full[r_rdBank];
    assign w_wrBankNext = r_wrBank ^ w_close;
    assign w_rdBankNext = r_rdBank ^ w_rel;

    always_comb begin
        w_full = '0;
        for (int b = 0; b < 2; b++) begin
            w_full[b] = (r_bankState[b] == BANK_FULL);
        end
    end

    // Release only ever targets a full bank and writes only a non-full one, so they never collide.
    always_comb begin
        w_fullNext = '0;
        for (int b = 0; b < 2; b++) begin
            w_bankNext[b] = r_bankState[b];
            if (w_rel && (r_rdBank == 1'(b))) begin
                w_bankNext[b] = BANK_EMPTY;
            end
            if (w_hs && (r_wrBank == 1'(b))) begin
                w_bankNext[b] = w_close ? BANK_FULL : BANK_FILLING;
            end
            w_fullNext[b] = (w_bankNext[b] == BANK_FULL);
        end
    end

    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrState      <= WR_RESET;
            r_bankState[0] <= BANK_EMPTY;
            r_bankState[1] <= BANK_EMPTY;
            r_wrBank       <= 1'b0;
            r_rdBank       <= 1'b0;
            r_idx          <= '0;
            r_sReady       <= 1'b0;
            r_wen          <= 1'b0;
            r_addr         <= '0;
            r_data         <= '0;
            r_tileValid    <= 1'b0;
        end else begin
            r_bankState[0] <= w_bankNext[0];
            r_bankState[1] <= w_bankNext[1];
            r_wrBank       <= w_wrBankNext;
            r_rdBank       <= w_rdBankNext;
            r_wen          <= w_hs;
            if (w_close) begin
                r_idx <= '0;
            end else if (w_hs) begin
                r_idx <= r_idx + 8'd1;
            end
            if (w_hs) begin
                r_addr <= {r_wrBank, r_idx};
                r_data <= bus.s_data;
            end
            r_tileValid <= w_full[r_rdBank];
            // Ready looks ahead at the bank the writer will own after this edge.
            if (w_fullNext[w_wrBankNext]) begin
                r_wrState <= WR_STALL;
                r_sReady  <= 1'b0;
            end else begin
                r_wrState <= WR_FILL;
                r_sReady  <= 1'b1;
            end
        end
    end

`ifdef SP_LOADER_LAST_CHECK_EN
    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_hs && (bus.s_last != w_idxEnd)) begin
            r_err <= 1'b1;
        end
    end
`endif

    assign bus.s_ready      = r_sReady;
    assign bus.wen          = r_wen;
    assign bus.data_in_addr = r_addr;
    assign bus.data_in      = r_data;
    assign bus.tile_valid   = r_tileValid;
    assign bus.tile_bank    = r_rdBank;

endmodule

// File: tb/tb_sp_tile_loader.sv
// Self-checking bench for sp_tile_loader: constant vector table, directed tile sequences,
// and randomized traffic checked against a word/tile counting reference model.
module tb_sp_tile_loader;
    localparam int DATA_W = 32;
    localparam int WORDS  = 130;
`ifdef SP_LOADER_LAST_CHECK_EN
    localparam bit LAST_CHECK_EN = 1'b1;
`else
    localparam bit LAST_CHECK_EN = 1'b0;
`endif

    logic write_clk = 1'b0;
    logic rst_n     = 1'b1;

    sp_tile_loader_if #(.DATA_W(DATA_W)) bus ();

    sp_tile_loader #(
        .SYS_WIDTH (64),
        .SYS_HEIGHT(1),
        .DATA_W    (DATA_W)
    ) dut (
        .write_clk(write_clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    always #5 write_clk = ~write_clk;

    int checksDone   = 0;
    int checksPassed = 0;

    // Reference model: words in the current tile, tiles completed, tiles released since reset.
    int          mWord;
    int          mDone;
    int          mRel;
    logic        mReady;
    logic        mTv;
    logic        mTb;
    logic        mWen;
    logic [8:0]  mAddr;
    logic [31:0] mData;
    logic        mErr;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        rel;
        logic        expWen;
        logic [8:0]  expAddr;
        logic        expReady;
        logic        expTv;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksDone++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mWord  = 0;
        mDone  = 0;
        mRel   = 0;
        mReady = 1'b0;
        mTv    = 1'b0;
        mTb    = 1'b0;
        mWen   = 1'b0;
        mAddr  = '0;
        mData  = '0;
        mErr   = 1'b0;
    endtask

    // Advance the model across one clock edge using the outputs it predicted before that edge.
    task automatic modelStep(input logic v, input logic [31:0] d, input logic rel, input logic last);
        logic hs;
        logic relOk;
        logic closeNow;
        int   prevOut;
        hs      = v && mReady;
        prevOut = mDone - mRel;
        relOk   = rel && mTv && (prevOut > 0);
        mWen    = hs;
        if (hs) begin
            mAddr    = 9'(((mDone % 2) * 256) + mWord);
            mData    = d;
            closeNow = (mWord == WORDS - 1) || (LAST_CHECK_EN && last);
            if (LAST_CHECK_EN && (last != (mWord == WORDS - 1))) begin
                mErr = 1'b1;
            end
            if (closeNow) begin
                mWord = 0;
                mDone++;
            end else begin
                mWord++;
            end
        end
        if (relOk) begin
            mRel++;
        end
        mTv    = (prevOut > 0);
        mReady = ((mDone - mRel) < 2);
        mTb    = 1'((mRel % 2) != 0);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " wen"}, 32'(bus.wen), 32'(mWen));
        if (mWen) begin
            checkOutput({tag, " addr"}, 32'(bus.data_in_addr), 32'(mAddr));
            checkOutput({tag, " data"}, bus.data_in, mData);
        end
        checkOutput({tag, " s_ready"}, 32'(bus.s_ready), 32'(mReady));
        checkOutput({tag, " tile_valid"}, 32'(bus.tile_valid), 32'(mTv));
        checkOutput({tag, " tile_bank"}, 32'(bus.tile_bank), 32'(mTb));
`ifdef SP_LOADER_LAST_CHECK_EN
        checkOutput({tag, " err"}, 32'(bus.err), 32'(mErr));
`endif
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " wen"}, 32'(bus.wen), 32'd0);
        checkOutput({tag, " addr"}, 32'(bus.data_in_addr), 32'd0);
        checkOutput({tag, " data"}, bus.data_in, 32'd0);
        checkOutput({tag, " s_ready"}, 32'(bus.s_ready), 32'd0);
        checkOutput({tag, " tile_valid"}, 32'(bus.tile_valid), 32'd0);
        checkOutput({tag, " tile_bank"}, 32'(bus.tile_bank), 32'd0);
`ifdef SP_LOADER_LAST_CHECK_EN
        checkOutput({tag, " err"}, 32'(bus.err), 32'd0);
`endif
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rel, input logic last, input string tag);
        bus.s_valid      = v;
        bus.s_data       = d;
        bus.tile_release = rel;
`ifdef SP_LOADER_LAST_CHECK_EN
        bus.s_last       = last;
`endif
        @(posedge write_clk);
        modelStep(v, d, rel, last);
        #1;
        checkModel(tag);
    endtask

    task automatic idleInputs();
        bus.s_valid      = 1'b0;
        bus.s_data       = '0;
        bus.tile_release = 1'b0;
`ifdef SP_LOADER_LAST_CHECK_EN
        bus.s_last       = 1'b0;
`endif
    endtask

    task automatic resetDut(input string tag);
        idleInputs();
        rst_n = 1'b0;
        #1;
        checkResetValues({tag, " in reset"});
        @(posedge write_clk);
        @(posedge write_clk);
        #3;
        rst_n = 1'b1;
        modelReset();
        #1;
        checkResetValues({tag, " after release"});
    endtask

    task automatic randomTraffic(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            applyStimulus(($urandom_range(0, 9) < 7), $urandom(), ($urandom_range(0, 9) == 0), 1'b0, tag);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int guard;

        vecs[0] = '{v: 1'b1, d: 32'hDEAD0000, rel: 1'b1, expWen: 1'b0, expAddr: 9'h000, expReady: 1'b1, expTv: 1'b0};
        vecs[1] = '{v: 1'b1, d: 32'h00000011, rel: 1'b0, expWen: 1'b1, expAddr: 9'h000, expReady: 1'b1, expTv: 1'b0};
        vecs[2] = '{v: 1'b0, d: 32'h0000BEEF, rel: 1'b0, expWen: 1'b0, expAddr: 9'h000, expReady: 1'b1, expTv: 1'b0};
        vecs[3] = '{v: 1'b1, d: 32'h00000022, rel: 1'b0, expWen: 1'b1, expAddr: 9'h001, expReady: 1'b1, expTv: 1'b0};
        vecs[4] = '{v: 1'b1, d: 32'h00000033, rel: 1'b1, expWen: 1'b1, expAddr: 9'h002, expReady: 1'b1, expTv: 1'b0};

        idleInputs();
        modelReset();
        #1;
        resetDut("reset");

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].rel, 1'b0, $sformatf("vec%0d model", i));
            checkOutput($sformatf("vec%0d wen", i), 32'(bus.wen), 32'(vecs[i].expWen));
            if (vecs[i].expWen) begin
                checkOutput($sformatf("vec%0d addr", i), 32'(bus.data_in_addr), 32'(vecs[i].expAddr));
                checkOutput($sformatf("vec%0d data", i), bus.data_in, vecs[i].d);
            end
            checkOutput($sformatf("vec%0d s_ready", i), 32'(bus.s_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d tile_valid", i), 32'(bus.tile_valid), 32'(vecs[i].expTv));
            checkOutput($sformatf("vec%0d tile_bank", i), 32'(bus.tile_bank), 32'd0);
        end

        $display("[TB] tile 0 back-to-back");
        resetDut("t1 reset");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, "t1 warmup");
        for (int k = 0; k < WORDS; k++) begin
            applyStimulus(1'b1, 32'(k), 1'b0, 1'(k == WORDS - 1), "t1 word");
        end
        checkOutput("t1 last addr", 32'(bus.data_in_addr), 32'h081);
        checkOutput("t1 tile_valid at last write", 32'(bus.tile_valid), 32'd0);

        $display("[TB] tile 1 back-to-back");
        for (int k = 0; k < WORDS; k++) begin
            applyStimulus(1'b1, 32'(WORDS + k), 1'b0, 1'(k == WORDS - 1), "t2 word");
            if (k == 0) begin
                checkOutput("t2 first addr", 32'(bus.data_in_addr), 32'h100);
                checkOutput("t2 tile_valid", 32'(bus.tile_valid), 32'd1);
            end
        end
        checkOutput("t2 last addr", 32'(bus.data_in_addr), 32'h181);
        checkOutput("t2 s_ready both full", 32'(bus.s_ready), 32'd0);
        checkOutput("t2 tile_bank", 32'(bus.tile_bank), 32'd0);
        applyStimulus(1'b1, 32'hFFFF, 1'b0, 1'b0, "t2 stall");
        checkOutput("t2 stall wen", 32'(bus.wen), 32'd0);

        $display("[TB] release bank 0");
        applyStimulus(1'b1, 32'hAAAA, 1'b1, 1'b0, "t3 release");
        checkOutput("t3 tile_bank", 32'(bus.tile_bank), 32'd1);
        checkOutput("t3 tile_valid", 32'(bus.tile_valid), 32'd1);
        checkOutput("t3 s_ready", 32'(bus.s_ready), 32'd1);
        applyStimulus(1'b1, 32'h5000, 1'b0, 1'b0, "t3 write");
        checkOutput("t3 write addr", 32'(bus.data_in_addr), 32'h000);

        $display("[TB] release coincident with completion");
        for (int k = 1; k < WORDS; k++) begin
            applyStimulus(1'b1, 32'h5000 + 32'(k), 1'b0, 1'(k == WORDS - 1), "t4 bank0");
        end
        checkOutput("t4 s_ready both full", 32'(bus.s_ready), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, "t4 release bank1");
        checkOutput("t4 tile_bank after release", 32'(bus.tile_bank), 32'd0);
        for (int k = 0; k < WORDS - 1; k++) begin
            applyStimulus(1'b1, 32'h6000 + 32'(k), 1'b0, 1'b0, "t4 bank1");
        end
        applyStimulus(1'b1, 32'h6081, 1'b1, 1'b1, "t4 final+release");
        checkOutput("t4 final addr", 32'(bus.data_in_addr), 32'h181);
        checkOutput("t4 tile_bank", 32'(bus.tile_bank), 32'd1);
        checkOutput("t4 tile_valid", 32'(bus.tile_valid), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, "t4 idle");
        checkOutput("t4 tile_valid next", 32'(bus.tile_valid), 32'd1);
        checkOutput("t4 s_ready bank0 free", 32'(bus.s_ready), 32'd1);

        $display("[TB] random traffic with mid-tile reset");
        randomTraffic(400, "t5 random");
        guard = 0;
        while ((mWord != 57) && (guard < 2000)) begin
            applyStimulus(($urandom_range(0, 9) < 7), $urandom(), ($urandom_range(0, 9) == 0), 1'b0, "t5 seek");
            guard++;
        end
        checkOutput("t5 reached idx57", 32'(guard < 2000), 32'd1);
        idleInputs();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("t5 async reset");
        @(posedge write_clk);
        #3;
        rst_n = 1'b1;
        modelReset();
        applyStimulus(1'b1, 32'h1234, 1'b0, 1'b0, "t5 ready cycle");
        checkOutput("t5 no write in ready cycle", 32'(bus.wen), 32'd0);
        applyStimulus(1'b1, 32'hABCD, 1'b0, 1'b0, "t5 first word");
        checkOutput("t5 first addr", 32'(bus.data_in_addr), 32'h000);
        checkOutput("t5 first data", bus.data_in, 32'hABCD);
        randomTraffic(1500, "t5 random2");

`ifdef SP_LOADER_LAST_CHECK_EN
        $display("[TB] early s_last");
        resetDut("t6 reset");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, "t6 warmup");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, 32'(k), 1'b0, 1'b0, "t6 word");
        end
        checkOutput("t6 err before last", 32'(bus.err), 32'd0);
        applyStimulus(1'b1, 32'd9, 1'b0, 1'b1, "t6 last");
        checkOutput("t6 err", 32'(bus.err), 32'd1);
        applyStimulus(1'b1, 32'd10, 1'b0, 1'b0, "t6 next tile");
        checkOutput("t6 next addr", 32'(bus.data_in_addr), 32'h100);
        checkOutput("t6 tile_valid", 32'(bus.tile_valid), 32'd1);
`endif

        idleInputs();
        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
